// File: rtl/uart_send_controller.sv
// Front-panel send bridge: synchronises and debounces the send button, captures the
// slide switches as payload and runs a level start / busy handshake with the UART TX.
module uart_send_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btn_send,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       tx_led,
  output logic [7:0] sent_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  logic [7:0]       sw_meta_r;
  logic [7:0]       sw_sync_r;
  logic             btn_meta_r;
  logic             btn_sync_r;
  logic             btn_db_r;
  logic             btn_db_q_r;
  logic [CNT_W-1:0] db_cnt_r;
  state_t           state_r;

  logic btn_differs_s;
  logic cnt_done_s;
  logic press_s;

  // Two-flop synchronisers for the asynchronous front-panel inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r  <= 8'h00;
      sw_sync_r  <= 8'h00;
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= btn_send;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Debounce qualifiers and the single-cycle press strobe
  always_comb begin
    btn_differs_s = (btn_sync_r != btn_db_r);
    cnt_done_s    = (db_cnt_r == CNT_LAST);
    press_s       = btn_db_r & ~btn_db_q_r;
  end

  // Debouncer: the new level is accepted only after DEBOUNCE_CYCLES differing edges in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_r   <= 1'b0;
      btn_db_q_r <= 1'b0;
      db_cnt_r   <= '0;
    end else begin
      btn_db_q_r <= btn_db_r;
      if (btn_differs_s) begin
        if (cnt_done_s) begin
          btn_db_r <= btn_sync_r;
          db_cnt_r <= '0;
        end else begin
          db_cnt_r <= db_cnt_r + CNT_W'(1);
        end
      end else begin
        db_cnt_r <= '0;
      end
    end
  end

  // Handshake FSM; presses seen outside IDLE are dropped, never queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      tx_led     <= 1'b0;
      sent_count <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (press_s) begin
            tx_data  <= sw_sync_r;
            tx_start <= 1'b1;
            tx_led   <= 1'b1;
            state_r  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!tx_busy) begin
            tx_led     <= 1'b0;
            sent_count <= sent_count + 8'd1;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          tx_led   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send_controller.sv
// Bench for uart_send_controller: random directed scenarios checked every cycle against
// a transaction-level reference model of the debounce / handshake behaviour.
module tb_uart_send_controller;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       btn_send = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_led;
  logic [7:0] sent_count;

  uart_send_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_send(btn_send), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .tx_led(tx_led), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: input pipelines, debounced level, transfer phase (0 idle, 1 request, 2 busy)
  bit         mq_btn[$];
  logic [7:0] mq_sw[$];
  bit         m_db, m_db_d;
  int         m_run, m_phase;
  logic [7:0] m_data, m_count;

  // bench-side transmitter
  int ack_delay = 1, busy_len = 1, req_wait = 0, busy_left = 0;
  bit busy_active = 1'b0;

  int edge_no = 0, start_rises = 0, start_cycles = 0;
  bit prev_start = 1'b0;

  function automatic void m_reset();
    mq_btn.delete(); mq_btn.push_back(1'b0); mq_btn.push_back(1'b0);
    mq_sw.delete();  mq_sw.push_back(8'h00); mq_sw.push_back(8'h00);
    m_db = 1'b0; m_db_d = 1'b0; m_run = 0; m_phase = 0;
    m_data = 8'h00; m_count = 8'h00;
    busy_active = 1'b0; busy_left = 0; req_wait = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_edge();
    bit press, s;
    logic [7:0] ssw;
    if (!rst_n) begin
      m_reset();
      return;
    end
    press = m_db && !m_db_d;
    ssw = mq_sw.pop_front();  mq_sw.push_back(sw);
    s   = mq_btn.pop_front(); mq_btn.push_back(btn_send);
    m_db_d = m_db;
    if (s != m_db) begin
      m_run++;
      if (m_run == D) begin
        m_db = s;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    case (m_phase)
      0: if (press) begin m_phase = 1; m_data = ssw; end
      1: if (tx_busy) m_phase = 2;
      default: if (!tx_busy) begin m_phase = 0; m_count = m_count + 8'd1; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    edge_no++;
    #1;
    chk("outputs", 32'({tx_start, tx_led, tx_data, sent_count}),
        32'({m_phase == 1, m_phase != 0, m_data, m_count}));
    if (tx_start && !prev_start) start_rises++;
    if (tx_start) start_cycles++;
    prev_start = tx_start;
    if (m_phase != 1) req_wait = 0;
    if (busy_active) begin
      if (busy_left == 0) busy_active = 1'b0;
      else busy_left--;
    end else if (m_phase == 1) begin
      if (req_wait >= ack_delay) begin
        busy_active = 1'b1;
        busy_left = busy_len - 1;
      end else begin
        req_wait++;
      end
    end
    tx_busy = busy_active;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_count(input logic [7:0] target, input int budget);
    int k = 0;
    while (sent_count !== target && k < budget) begin
      step();
      k++;
    end
    chk("send_done", 32'(sent_count), 32'(target));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_send = 1'b0;
    tx_busy = 1'b0;
    m_reset();
    repeat (2) step();
    rst_n = 1'b1;
    start_rises = 0;
    start_cycles = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, hi, lo, first_start;
    logic [7:0] v1, v2;

    m_reset();
    do_reset();
    chk("reset_outputs", 32'({tx_start, tx_led, tx_data, sent_count}), 32'd0);

    // basic send
    sw = 8'hA5; ack_delay = 1; busy_len = 10; btn_send = 1'b1;
    edge_no = -1; first_start = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx_start && first_start < 0) first_start = edge_no;
    end
    chk("basic_start_edge", 32'(first_start), 32'd6);
    chk("basic_data", 32'(tx_data), 32'h0000_00A5);
    chk("basic_count", 32'(sent_count), 32'd1);
    chk("basic_rises", 32'(start_rises), 32'd1);
    btn_send = 1'b0;
    run(10);

    // bounce rejection
    do_reset();
    sw = 8'($urandom); ack_delay = int'($urandom_range(0, 3)); busy_len = int'($urandom_range(1, 5));
    k = 0;
    while (k < 40) begin
      hi = int'($urandom_range(1, 3));
      lo = int'($urandom_range(1, 3));
      btn_send = 1'b1; run(hi);
      btn_send = 1'b0; run(lo);
      k = k + hi + lo;
    end
    chk("bounce_no_start", 32'(start_rises), 32'd0);
    btn_send = 1'b1;
    run(30);
    chk("bounce_rises", 32'(start_rises), 32'd1);
    chk("bounce_count", 32'(sent_count), 32'd1);
    btn_send = 1'b0;
    run(10);

    // second press while the transmitter is busy
    do_reset();
    v1 = 8'($urandom); v2 = ~v1;
    sw = v1; ack_delay = 1; busy_len = 40; btn_send = 1'b1;
    run(9);
    btn_send = 1'b0; sw = v2;
    run(10);
    btn_send = 1'b1;
    run(12);
    chk("busy_press_led", 32'(tx_led), 32'd1);
    chk("busy_press_data", 32'(tx_data), 32'(v1));
    run(30);
    chk("busy_press_count", 32'(sent_count), 32'd1);
    chk("busy_press_rises", 32'(start_rises), 32'd1);
    chk("busy_press_data_end", 32'(tx_data), 32'(v1));
    btn_send = 1'b0;
    run(10);

    // 256 sends wrap the counter
    do_reset();
    for (int n = 0; n < 256; n++) begin
      v1 = 8'($urandom);
      sw = v1;
      ack_delay = int'($urandom_range(0, 2));
      busy_len = int'($urandom_range(1, 3));
      btn_send = 1'b1;
      wait_count(8'(n + 1), 60);
      chk("wrap_data", 32'(tx_data), 32'(v1));
      btn_send = 1'b0;
      sw = 8'($urandom);
      run(8);
    end
    chk("wrap_final", 32'(sent_count), 32'd0);

    // asynchronous reset while requesting, button held across release
    do_reset();
    sw = 8'h3C; ack_delay = 1000; busy_len = 1; btn_send = 1'b1;
    k = 0;
    while (tx_start !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("req_reached", 32'(tx_start), 32'd1);
    run(5);
    chk("req_no_timeout", 32'(tx_start), 32'd1);
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_outputs", 32'({tx_start, tx_led, tx_data, sent_count}), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    start_rises = 0;
    ack_delay = 1; busy_len = 3;
    run(30);
    chk("rst_resend_rises", 32'(start_rises), 32'd1);
    chk("rst_resend_count", 32'(sent_count), 32'd1);
    chk("rst_resend_data", 32'(tx_data), 32'h0000_003C);
    btn_send = 1'b0;
    run(10);

    // immediate acknowledge with minimum busy phase
    do_reset();
    sw = 8'($urandom); ack_delay = 0; busy_len = 1; btn_send = 1'b1;
    run(20);
    chk("imm_start_cycles", 32'(start_cycles), 32'd1);
    chk("imm_count", 32'(sent_count), 32'd1);
    chk("imm_led", 32'(tx_led), 32'd0);
    btn_send = 1'b0;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_send_controller.md
# uart_send_controller

Front-panel-to-transmitter bridge for the UART lab: synchronises and debounces the send push-button, captures the 8 slide switches as the payload and runs a start/busy handshake with the UART transmitter. It is the input-side counterpart of the LED status path. Its `tx_led` output drives the transmit-activity LED, and `sent_count` is exposed for display.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000; consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); minimum 2.
- `CNT_W`, default 20; debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sw`  in  8  raw slide switches; payload source.
- `btn_send`  in  1  raw push-button, active-high, asynchronous and bouncy.
- `tx_busy`  in  1  transmitter busy, synchronous to `clk`.
- `tx_data`  out  8  byte presented to the transmitter.
- `tx_start`  out  1  transmit request (level, held until acknowledged).
- `tx_led`  out  1  high while a send is in progress.
- `sent_count`  out  8  number of completed sends, modulo 256.

## Operation
- **Input synchronisation:** `sw` and `btn_send` each pass through a 2-flop synchroniser.
- **Debouncer:**
  - Holds a stable level `btn_db`, reset value 0.
  - Each edge where the synced button differs from `btn_db`, the counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, `btn_db` takes the synced level and the counter clears.
  - Any edge where the levels are equal clears the counter.
- **Press event:** `btn_db` is 1 and its registered copy is 0. This is one press per debounced rising edge; release generates nothing.
- **FSM, IDLE:**
  - `tx_start`=0, `tx_led`=0.
  - On a press event: `tx_data` latches the synced `sw`, then go to REQ.
- **FSM, REQ:**
  - `tx_start`=1, `tx_led`=1.
  - When `tx_busy` is sampled 1, go to WAIT.
- **FSM, WAIT:**
  - `tx_start`=0, `tx_led`=1.
  - When `tx_busy` is sampled 0, `sent_count` increments and the FSM goes to IDLE.
- **Presses outside IDLE:** ignored and never queued.
- **`tx_data`:** changes only on IDLE→REQ, so it is stable throughout REQ and WAIT.
- **`sent_count`:** 8-bit, wraps 255→0.
- **Outputs:** all are registered, with no combinational paths from inputs.

## Timing
- **Reset values:** every output is 0, state = IDLE, `btn_db` = 0, counter = 0, synchronisers = 0.
- **Reset asserted mid-send:** the transfer is abandoned and `tx_start` drops immediately (asynchronously).
- **Button held across reset release:** this produces exactly one new send, because `btn_db` restarts at 0.
- **Press latency:** with `btn_send` first sampled high at edge 0 and held, `btn_db` rises after edge D+1 and `tx_start` rises after edge D+2 (D = DEBOUNCE_CYCLES).
- **Payload capture:** `tx_data` reflects `sw` as it was at edge D.
- **Glitch rejection:** a button pulse high for fewer than D cycles after synchronisation never changes `btn_db`.
- **Same-cycle acknowledge:** `tx_busy` already 1 in the first REQ cycle means `tx_start` is high for exactly one cycle.
- **Minimum busy phase:** `tx_busy` dropping in the cycle right after entering WAIT means the FSM returns to IDLE on that edge, and `sent_count` updates on the same edge.
- **No timeout:** REQ waits indefinitely for `tx_busy`.
- **Back-to-back sends:** the next press may be accepted on the edge after returning to IDLE.

## Test plan
All tests use DEBOUNCE_CYCLES=4.
- **Basic send:**
  - Stimulus: `sw`=8'hA5; `btn_send` high from edge 0; model sets `tx_busy` high 1 cycle after `tx_start` and keeps it high 10 cycles.
  - Response: `tx_start` rises after edge 6 with `tx_data`=8'hA5; it falls on the edge after `tx_busy`=1; `tx_led` is high for the whole transfer; `sent_count` goes 0→1 when `tx_busy` falls.
- **Bounce rejection:** `btn_send` toggles with 1–3 cycle high pulses for 40 cycles, then held high → exactly one `tx_start` assertion; `sent_count`=1 after completion.
- **Press while busy:** a second debounced press while in WAIT → ignored; `tx_data` unchanged; `sent_count` increments only once.
- **Wrap-around:** 256 complete sends with varying `sw` → `sent_count` returns to 8'h00; each `tx_data` matches its `sw`.
- **Async reset mid-REQ:** `rst_n` low while `tx_start`=1 → `tx_start`, `tx_led`, `tx_data` and `sent_count` are 0 before the next clock edge; after release with the button held, one new send is observed.
- **Immediate acknowledge:** `tx_busy` already 1 when REQ is entered, dropping 1 cycle later → `tx_start` high exactly 1 cycle; FSM returns to IDLE with `sent_count` incremented.
